// File: rtl/skinny_inv_subcells_serial.sv
// Serial 3-share masked inverse SubCells for SKINNY-64 decryption.
// One nibble per cycle passes through two quadratic masked stages:
//   stage 1: w = (A, y3, y2, B) with A = y0^1^y3^y2^y2y3, B = y0^y1^y2^y2y3^y0y3
//            (the first two NOR/XOR steps of the inverse S-box), refreshed with r
//   stage 2: out = (C, B, A, D) with C = y2^1^B^A^BA, D = y3^y2^A^BA^BY2
// Each share of a masked product uses only two of the three input shares.
module skinny_inv_subcells_serial #(
  parameter int NUM_NIBBLES = 16,
  parameter int CNT_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [4*NUM_NIBBLES-1:0] in1,
  input  logic [4*NUM_NIBBLES-1:0] in2,
  input  logic [4*NUM_NIBBLES-1:0] in3,
  input  logic [7:0]               r,
  output logic                     busy,
  output logic                     done,
  output logic [4*NUM_NIBBLES-1:0] out1,
  output logic [4*NUM_NIBBLES-1:0] out2,
  output logic [4*NUM_NIBBLES-1:0] out3
);

  localparam int W = 4 * NUM_NIBBLES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_en, shift_en, out_en;

  // Per-share datapath registers (index = share number - 1)
  logic [W-1:0] in_sh  [3];
  logic [W-1:0] sh_q   [3];
  logic [3:0]   stg_q  [3];
  logic [W-1:0] out_q  [3];
  logic [3:0]   s1_out [3];
  logic [3:0]   s2_out [3];

  // Bit-sliced share vectors: vec[k][j] = bit k of share j
  logic [2:0] yb    [4];
  logic [2:0] wb    [4];
  logic [2:0] zb    [4];
  logic [2:0] ob    [4];
  logic [2:0] rmask [4];
  logic [2:0] p23, p03, pba, pby2;

  // Linear term routing: output share j takes input share j+1 (mod 3).
  function automatic logic [2:0] lin3(input logic [2:0] a);
    return {a[0], a[2], a[1]};
  endfunction

  // Non-complete 3-share AND: each output share misses one input share.
  function automatic logic [2:0] ti_and(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] o;
    o[0] = (a[1] & b[1]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
    o[1] = (a[2] & b[2]) ^ (a[0] & b[2]) ^ (a[2] & b[0]);
    o[2] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
    return o;
  endfunction

  assign in_sh[0] = in1;
  assign in_sh[1] = in2;
  assign in_sh[2] = in3;

  // Two fresh bits per stage-1 output bit; the three masks XOR to zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rmask
      assign rmask[gi] = {r[2*gi] ^ r[2*gi+1], r[2*gi+1], r[2*gi]};
    end
  endgenerate

  // FSM state, counter and status flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and datapath enables
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    out_en   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          load_en = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        shift_en = 1'b1;
        // Stage register holds a real nibble from the second RUN cycle on
        out_en   = (cnt_q != '0);
        cnt_d    = cnt_q + CNT_W'(1);
        busy_d   = 1'b1;
        if (cnt_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        out_en  = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Stage 1: A2^-1 and masked G^-1 on the top nibble of each share, refreshed by r
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        yb[k][j] = sh_q[j][W-4+k];
      end
    end
    p23   = ti_and(yb[2], yb[3]);
    p03   = ti_and(yb[0], yb[3]);
    wb[3] = lin3(yb[0]) ^ lin3(yb[3]) ^ lin3(yb[2]) ^ p23 ^ 3'b001;
    wb[2] = lin3(yb[3]);
    wb[1] = lin3(yb[2]);
    wb[0] = lin3(yb[0]) ^ lin3(yb[1]) ^ lin3(yb[2]) ^ p23 ^ p03;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        s1_out[j][k] = wb[k][j] ^ rmask[k][j];
      end
    end
  end

  // Stage 2: masked F^-1 and A1^-1 on the registered stage-1 shares
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        zb[k][j] = stg_q[j][k];
      end
    end
    // zb[3] = A, zb[2] = y3, zb[1] = y2, zb[0] = B
    pba   = ti_and(zb[0], zb[3]);
    pby2  = ti_and(zb[0], zb[1]);
    ob[3] = lin3(zb[1]) ^ lin3(zb[0]) ^ lin3(zb[3]) ^ pba ^ 3'b001;
    ob[2] = lin3(zb[0]);
    ob[1] = lin3(zb[3]);
    ob[0] = lin3(zb[2]) ^ lin3(zb[1]) ^ lin3(zb[3]) ^ pba ^ pby2;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        s2_out[j][k] = ob[k][j];
      end
    end
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_share
      // Input shift register: load on accepted start, feed MSB nibble each RUN cycle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sh_q[gi] <= '0;
        end else if (load_en) begin
          sh_q[gi] <= in_sh[gi];
        end else if (shift_en) begin
          sh_q[gi] <= {sh_q[gi][W-5:0], 4'h0};
        end
      end

      // Share register between the two stages
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stg_q[gi] <= '0;
        end else if (shift_en) begin
          stg_q[gi] <= s1_out[gi];
        end
      end

      // Output assembly: stage-2 nibbles enter at the LSB so order is preserved
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q[gi] <= '0;
        end else if (out_en) begin
          out_q[gi] <= {out_q[gi][W-5:0], s2_out[gi]};
        end
      end
    end
  endgenerate

  assign busy = busy_q;
  assign done = done_q;
  assign out1 = out_q[0];
  assign out2 = out_q[1];
  assign out3 = out_q[2];

endmodule
